// File: rtl/regfile_scanner.sv
// regfile_scanner: walks an inclusive register index range two registers per fetch and streams (idx, data) beats.
// Latency: 1 FETCH cycle per register pair, then one beat per register; done pulses one cycle after the final accepted beat.
// Backpressure: out_valid/out_ready handshake; beats are held stable while out_ready is low and no new fetch is issued.
//
// Ports: clk/rst (async active-high); start + first_idx/last_idx request a scan;
//        src_a/src_b select two register-file read ports, reg_a/reg_b return their data combinationally;
//        out_valid/out_ready/out_idx/out_data/out_last form the output stream; busy/done report scan status.
// Optional: define SCANNER_CHECKSUM_EN to add a `checksum` output, the XOR of every accepted out_data of the
//           current scan (cleared on accepted start, held after done).
module regfile_scanner #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [IDX_W-1:0]  first_idx,
    input  logic [IDX_W-1:0]  last_idx,
    output logic [IDX_W-1:0]  src_a,
    output logic [IDX_W-1:0]  src_b,
    input  logic [DATA_W-1:0] reg_a,
    input  logic [DATA_W-1:0] reg_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  out_idx,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
`ifdef SCANNER_CHECKSUM_EN
    output logic [DATA_W-1:0] checksum,
`endif
    output logic              done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_EMIT0 = 3'd2;
    localparam logic [2:0] S_EMIT1 = 3'd3;
    localparam logic [2:0] S_FIN   = 3'd4;

    logic [2:0]        state;
    // One extra bit so cursor+1 / cursor+2 past the top index never alias back to 0.
    logic [IDX_W:0]    cursor;
    logic [IDX_W:0]    last_q;
    logic [IDX_W:0]    cursor_p1;
    logic [DATA_W-1:0] buf_a;
    logic [DATA_W-1:0] buf_b;
    logic              beat_acc;

    assign cursor_p1 = cursor + (IDX_W+1)'(1);
    assign beat_acc  = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            cursor <= '0;
            last_q <= '0;
            src_a  <= '0;
            src_b  <= '0;
            buf_a  <= '0;
            buf_b  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        last_q <= {1'b0, last_idx};
                        if (last_idx < first_idx) begin
                            state <= S_FIN;
                        end else begin
                            cursor <= {1'b0, first_idx};
                            // Read selects are set up here so they are already valid during FETCH.
                            src_a  <= first_idx;
                            src_b  <= first_idx + IDX_W'(1);
                            state  <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    buf_a <= reg_a;
                    buf_b <= reg_b;
                    state <= S_EMIT0;
                end
                S_EMIT0: begin
                    if (out_ready) begin
                        state <= (cursor == last_q) ? S_FIN : S_EMIT1;
                    end
                end
                S_EMIT1: begin
                    if (out_ready) begin
                        if (cursor_p1 == last_q) begin
                            state <= S_FIN;
                        end else begin
                            // cursor+1 < last here, so cursor+2 is still a legal index.
                            cursor <= cursor + (IDX_W+1)'(2);
                            src_a  <= cursor[IDX_W-1:0] + IDX_W'(2);
                            // May exceed the top index; the fetched value is then never emitted.
                            src_b  <= cursor[IDX_W-1:0] + IDX_W'(3);
                            state  <= S_FETCH;
                        end
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef SCANNER_CHECKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            checksum <= '0;
        end else if (state == S_IDLE && start) begin
            checksum <= '0;
        end else if (beat_acc) begin
            checksum <= checksum ^ out_data;
        end
    end
`endif

    always_comb begin
        out_idx  = '0;
        out_data = '0;
        out_last = 1'b0;
        case (state)
            S_EMIT0: begin
                out_idx  = cursor[IDX_W-1:0];
                out_data = buf_a;
                out_last = (cursor == last_q);
            end
            S_EMIT1: begin
                out_idx  = cursor_p1[IDX_W-1:0];
                out_data = buf_b;
                out_last = (cursor_p1 == last_q);
            end
            default: begin
                out_idx  = '0;
                out_data = '0;
                out_last = 1'b0;
            end
        endcase
    end

    assign out_valid = (state == S_EMIT0) || (state == S_EMIT1);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_FIN);

endmodule
